adc_spi_multi: RTL and testbench

ADC_SPI_MULTI -- requirements
Module: adc_spi_multi

---
 rtl/adc_spi_multi.sv | 158 +++++++++++++++
 tb/tb_adc_spi_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_multi.sv
// Multi-channel SPI reader for LTC2315-class ADCs sharing sck/CS.
// Each ADC has its own sdo line, and every channel is captured in the same frame.
module adc_spi_multi #(
  parameter int NCH     = 2,
  parameter int DW      = 12,
  parameter int LEAD    = 1,
  parameter int FRAME   = 16,
  parameter int SCK_DIV = 2,
  parameter int T_CONV  = 4
) (
  input  logic              clk_100,
  input  logic              reset_n,
  input  logic              start,
  input  logic              trig,
  output logic              sck,
  output logic              CS,
  input  logic [NCH-1:0]    sdo,
  output logic [NCH*DW-1:0] adc_data,
  output logic              valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CONV_W = $clog2(T_CONV + 1);
  localparam int DIV_W  = $clog2(SCK_DIV);
  localparam int BIT_W  = $clog2(FRAME + 1);

  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(T_CONV - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(SCK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME - 1);
  localparam logic [BIT_W-1:0]  WIN_START = BIT_W'(LEAD);
  localparam logic [BIT_W-1:0]  WIN_LEN   = BIT_W'(DW);

  logic [1:0]              state_q, state_d;
  logic [CONV_W-1:0]       conv_q, conv_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [NCH-1:0][DW-1:0]  shreg_q, shreg_d;
  logic [NCH*DW-1:0]       adc_q, adc_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    cs_q, cs_d;
  logic                    sck_q, sck_d;
  logic [BIT_W-1:0]        win_off;
  logic                    in_win;

  always_comb begin
    state_d   = state_q;
    conv_d    = conv_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    adc_d     = adc_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    // Wrapping subtraction: samples before the window land far above WIN_LEN.
    win_off   = bit_q - WIN_START;
    in_win    = (win_off < WIN_LEN);

    if (trig && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start || trig) begin
          state_d = S_CONV;
          conv_d  = '0;
        end
      end
      S_CONV: begin
        if (conv_q == CONV_LAST) begin
          state_d = S_SHIFT;
          conv_d  = '0;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          conv_d = conv_q + CONV_W'(1);
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          // End of the high phase: sample every channel as sck drops.
          div_d = '0;
          if (in_win) begin
            for (int unsigned i = 0; i < NCH; i++) begin
              shreg_d[i] = {shreg_q[i][DW-2:0], sdo[i]};
            end
          end
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
            bit_d   = '0;
            adc_d   = shreg_d;
            valid_d = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = start ? S_CONV : S_IDLE;
        conv_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    cs_d   = (state_d != S_SHIFT);
    sck_d  = (state_d == S_SHIFT) && (div_d >= DIV_HALF);
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      conv_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      adc_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      conv_q    <= conv_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      adc_q     <= adc_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign CS       = cs_q;
  assign adc_data = adc_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_adc_spi_multi.sv
// Scoreboard bench for adc_spi_multi: a default 2-channel instance fed by ADC models,
// plus a 4-channel 16-bit instance with sdo tied high.
module tb_adc_spi_multi;

  logic        clk;
  logic        rst_n;
  logic        start, trig, trig4;
  logic        sck0, cs0, valid0, busy0, overrun0;
  logic [1:0]  sdo0;
  logic [23:0] adc_data0;
  logic        sck4, cs4, valid4, busy4, overrun4;
  logic [3:0]  sdo4;
  logic [63:0] adc_data4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int vcount = 0;
  int last_vcyc = 0;
  int v4cnt = 0;
  int v4cyc = 0;
  int vcyc_q[$];
  logic [23:0] stim_q[$];
  logic [23:0] exp_q[$];
  logic [63:0] exp4_q[$];

  logic [23:0] cur = '0;
  int unsigned idx = 0;
  logic        in_frame = 1'b0;
  logic        sck_prev = 1'b0;

  adc_spi_multi u_dut (
    .clk_100 (clk),
    .reset_n (rst_n),
    .start   (start),
    .trig    (trig),
    .sck     (sck0),
    .CS      (cs0),
    .sdo     (sdo0),
    .adc_data(adc_data0),
    .valid   (valid0),
    .busy    (busy0),
    .overrun (overrun0)
  );

  adc_spi_multi #(.NCH(4), .DW(16), .LEAD(0), .FRAME(16), .SCK_DIV(4), .T_CONV(4)) u_dut4 (
    .clk_100 (clk),
    .reset_n (rst_n),
    .start   (1'b0),
    .trig    (trig4),
    .sck     (sck4),
    .CS      (cs4),
    .sdo     (sdo4),
    .adc_data(adc_data4),
    .valid   (valid4),
    .busy    (busy4),
    .overrun (overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC frame: LEAD zeros, 12 data bits MSB first, then zeros.
  function automatic logic bitval(input logic [11:0] d, input int unsigned k);
    if (k < 1) return 1'b0;
    if (k < 13) return d[12-k];
    return 1'b0;
  endfunction

  assign sdo0 = {bitval(cur[23:12], idx), bitval(cur[11:0], idx)};
  assign sdo4 = '1;

  // ADC model: new word on CS fall, next bit after each sck fall.
  always @(posedge clk) begin
    #2;
    if (cs0) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      in_frame = 1'b1;
      idx = 0;
      if (stim_q.size() > 0) cur = stim_q.pop_front();
      else cur = 24'($urandom);
      exp_q.push_back(cur);
    end else if (sck_prev && !sck0) begin
      idx++;
    end
    sck_prev = sck0;
  end

  always @(negedge clk) begin
    if (valid0) begin
      vcount++;
      last_vcyc = cyc;
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("sb_unexpected_valid", 1, 0);
      else check("adc_data", {40'd0, adc_data0}, {40'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (valid4) begin
      v4cnt++;
      v4cyc = cyc;
      if (exp4_q.size() == 0) check("sb4_unexpected_valid", 1, 0);
      else check("adc_data4", adc_data4, exp4_q.pop_front());
    end
  end

  task automatic pulse_trig(output int c0);
    @(negedge clk);
    trig = 1'b1;
    c0 = cyc;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget);
    int n = 0;
    while (vcount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (vcount < target) check("valid_timeout", 64'(vcount), 64'(target));
  endtask

  initial begin
    int c0, c1, base, vb, r0, r1, rises, n;
    logic last;
    rst_n = 1'b0; start = 1'b0; trig = 1'b0; trig4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(cs0), 1);
    check("rst_sck", 64'(sck0), 0);
    check("rst_valid", 64'(valid0), 0);
    check("rst_busy", 64'(busy0), 0);
    check("rst_overrun", 64'(overrun0), 0);
    check("rst_data", 64'(adc_data0), 0);
    check("rst_cs4", 64'(cs4), 1);
    rst_n = 1'b1;

    // Single trig conversion; latency spans trig cycle through valid cycle.
    stim_q.push_back(24'h3F1A5C);
    base = vcount;
    pulse_trig(c0);
    wait_valid(base + 1, 100);
    check("lat_single", 64'(last_vcyc - c0 + 1), 38);
    while (cyc <= last_vcyc) @(negedge clk);
    check("valid_one_cycle", 64'(valid0), 0);
    check("idle_busy", 64'(busy0), 0);
    check("idle_cs", 64'(cs0), 1);
    check("no_overrun", 64'(overrun0), 0);

    // Continuous mode, start and trig together; start dropped during frame 3.
    stim_q.push_back(24'h0FF800);
    stim_q.push_back(24'hABCDEF);
    stim_q.push_back(24'h001FFE);
    base = vcount;
    vb = vcyc_q.size();
    @(negedge clk);
    start = 1'b1; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_valid(base + 2, 150);
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_valid(base + 3, 100);
    check("period_1", 64'(vcyc_q[vb+1] - vcyc_q[vb]), 37);
    check("period_2", 64'(vcyc_q[vb+2] - vcyc_q[vb+1]), 37);
    repeat (60) @(negedge clk);
    check("cont_frames", 64'(vcount - base), 3);
    check("cont_busy", 64'(busy0), 0);
    check("cont_cs", 64'(cs0), 1);
    check("cont_sck", 64'(sck0), 0);
    check("start_trig_no_overrun", 64'(overrun0), 0);
    check("data_hold", 64'(adc_data0), 64'h001FFE);

    // trig during SHIFT: overrun sticks, no extra frame.
    stim_q.push_back(24'h555AAA);
    base = vcount;
    pulse_trig(c0);
    repeat (15) @(negedge clk);
    pulse_trig(c1);
    check("overrun_set", 64'(overrun0), 1);
    wait_valid(base + 1, 100);
    repeat (80) @(negedge clk);
    check("overrun_frames", 64'(vcount - base), 1);
    check("overrun_sticky", 64'(overrun0), 1);
    check("overrun_idle", 64'(busy0), 0);

    // Reset at SHIFT cycle 10.
    stim_q.push_back(24'hFFF000);
    base = vcount;
    pulse_trig(c0);
    while (cyc < c0 + 15) @(negedge clk);
    check("in_shift", 64'(cs0), 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs", 64'(cs0), 1);
    check("abort_sck", 64'(sck0), 0);
    check("abort_data", 64'(adc_data0), 0);
    check("abort_busy", 64'(busy0), 0);
    check("abort_overrun", 64'(overrun0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("abort_no_valid", 64'(vcount - base), 0);
    stim_q.push_back(24'hC965A3);
    pulse_trig(c0);
    wait_valid(base + 1, 100);
    check("lat_after_reset", 64'(last_vcyc - c0 + 1), 38);

    // Wide instance: sck period and latency.
    exp4_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    trig4 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    trig4 = 1'b0;
    rises = 0; r0 = 0; r1 = 0; last = sck4;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(negedge clk);
      if (sck4 && !last) begin
        if (rises == 0) r0 = cyc;
        else r1 = cyc;
        rises++;
      end
      last = sck4;
    end
    check("sck4_period", 64'(r1 - r0), 4);
    n = 0;
    while (v4cnt < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("valid4_count", 64'(v4cnt), 1);
    check("lat4", 64'(v4cyc - c0 + 1), 70);
    repeat (3) @(negedge clk);
    check("busy4_idle", 64'(busy4), 0);
    check("overrun4", 64'(overrun4), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1);
  end

endmodule
